// File: rtl/rgb_pwm_pkg.sv
// RGB PWM controller: shared register map and CTRL bit positions.
// Used by rgb_pwm_ctrl and the bench.
package rgb_pwm_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_PRESC  = 4'd1;
    localparam logic [3:0] ADDR_STATUS = 4'd2;
    localparam logic [3:0] ADDR_DUTY0  = 4'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_INV = 1;

    // Bus address of duty register idx
    function automatic logic [3:0] duty_addr(input int idx);
        return ADDR_DUTY0 + 4'(idx);
    endfunction

endpackage

// File: rtl/rgb_pwm_ctrl_chan.sv
// One PWM channel: shadow/active duty pair and the compare.
// With RGB_PWM_FADE_EN the wrap-time load steps by one count toward shadow.
module pwm_chan #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr,
    input  logic [PWM_BITS-1:0] wdata,
    input  logic                load,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                en,
    input  logic                inv,
    output logic                pwm,
    output logic [PWM_BITS-1:0] shadow
);

    logic [PWM_BITS-1:0] active;

    // Shadow duty takes bus writes at any time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (wr) begin
            shadow <= wdata;
        end
    end

    // Active duty: immediate load on enable, otherwise updated only at wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= '0;
        end else if (load) begin
            active <= shadow;
        end else if (wrap) begin
`ifdef RGB_PWM_FADE_EN
            if (active < shadow) begin
                active <= active + 1'b1;
            end else if (active > shadow) begin
                active <= active - 1'b1;
            end
`else
            active <= shadow;
`endif
        end
    end

    assign pwm = (en & (cnt < active)) ^ inv;

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// RGB PWM controller: bus registers, prescaler, shared counter, NCH channels.
// Optional duty fading is compiled in with macro RGB_PWM_FADE_EN.
module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter int NCH        = 3,
    parameter int PWM_BITS   = 8,
    parameter int PRESC_BITS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cs,
    input  logic           we,
    input  logic [3:0]     addr,
    input  logic [7:0]     din,
    output logic [7:0]     dout,
    output logic [NCH-1:0] pwm_o,
    output logic           wrap_o
);

    logic                  en;
    logic                  inv;
    logic                  sticky;
    logic [PRESC_BITS-1:0] presc;
    logic [PRESC_BITS-1:0] psc;
    logic [PWM_BITS-1:0]   cnt;
    logic [PWM_BITS-1:0]   shadow [NCH];
    logic [7:0]            rdata;

    logic wr_stb;
    logic rd_stb;
    logic ctrl_wr;
    logic en_nxt;
    logic en_rise;
    logic tick;
    logic wrap;

    assign wr_stb  = cs & we;
    assign rd_stb  = cs & ~we;
    assign ctrl_wr = wr_stb & (addr == ADDR_CTRL);
    assign en_nxt  = ctrl_wr ? din[CTRL_EN] : en;
    assign en_rise = ~en & en_nxt;
    // No tick on the edge that disables the block
    assign tick    = en & en_nxt & (psc == presc);
    assign wrap    = tick & (cnt == '1);

    // Control and prescale registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en    <= 1'b0;
            inv   <= 1'b0;
            presc <= '0;
        end else begin
            en <= en_nxt;
            if (ctrl_wr) begin
                inv <= din[CTRL_INV];
            end
            if (wr_stb && addr == ADDR_PRESC) begin
                presc <= din[PRESC_BITS-1:0];
            end
        end
    end

    // Prescaler and PWM counter; held at zero while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc <= '0;
            cnt <= '0;
        end else if (!en_nxt) begin
            psc <= '0;
            cnt <= '0;
        end else if (en) begin
            if (tick) begin
                psc <= '0;
                cnt <= cnt + 1'b1;
            end else if (psc > presc) begin
                psc <= '0;
            end else begin
                psc <= psc + 1'b1;
            end
        end
    end

    // Wrap pulse and sticky status; a set beats a clearing read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_o <= 1'b0;
            sticky <= 1'b0;
        end else begin
            wrap_o <= wrap;
            if (wrap) begin
                sticky <= 1'b1;
            end else if (rd_stb && addr == ADDR_STATUS) begin
                sticky <= 1'b0;
            end
        end
    end

    // Read mux
    always_comb begin
        rdata = 8'h00;
        case (addr)
            ADDR_CTRL: begin
                rdata[CTRL_EN]  = en;
                rdata[CTRL_INV] = inv;
            end
            ADDR_PRESC:  rdata = 8'(presc);
            ADDR_STATUS: rdata = {7'b0, sticky};
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (addr == duty_addr(i)) begin
                        rdata = 8'(shadow[i]);
                    end
                end
            end
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 8'h00;
        end else if (rd_stb) begin
            dout <= rdata;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic dwr;
        assign dwr = wr_stb & (addr == duty_addr(i));

        pwm_chan #(
            .PWM_BITS(PWM_BITS)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (dwr),
            .wdata (din[PWM_BITS-1:0]),
            .load  (en_rise),
            .wrap  (wrap),
            .cnt   (cnt),
            .en    (en),
            .inv   (inv),
            .pwm   (pwm_o[i]),
            .shadow(shadow[i])
        );
    end

endmodule

// File: doc/rgb_pwm_ctrl.md
RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 3, giving the PWM channel count (1..8).
REQ-002 SHALL have parameter PWM_BITS, default 8, giving the PWM counter and duty width (4..8).
REQ-003 SHALL have parameter PRESC_BITS, default 8, giving the prescaler width (1..8).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock (the 12 MHz core clock).
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cs, input, 1 bit: peripheral select from the 6502 address decode.
REQ-007 SHALL have port we, input, 1 bit: write strobe, qualified by cs.
REQ-008 SHALL have port addr, input, 4 bits: register index.
REQ-009 SHALL have port din, input, 8 bits: write data.
REQ-010 SHALL have port dout, output, 8 bits: registered read data.
REQ-011 SHALL have port pwm_o, output, NCH bits: PWM outputs, active-high before the optional invert.
REQ-012 SHALL have port wrap_o, output, 1 bit: one-cycle pulse at each PWM period wrap.

Function
REQ-013 SHALL use this register map:
- 0 CTRL: bit0 EN, bit1 INV.
- 1 PRESC.
- 2 STATUS: bit0 WRAP sticky, read-only.
- 3..3+NCH-1 DUTY[n].
- All other addresses read 0x00 and ignore writes.
REQ-014 SHALL take a write on the rising clk edge when cs=1 and we=1; register fields narrower than 8 bits take the LSBs of din.
REQ-015 SHALL register dout one cycle after a cycle with cs=1 and we=0; dout holds its value when not reading.
REQ-016 SHALL, when EN=1, count the prescaler 0..PRESC and issue a tick on reaching PRESC; PRESC=0 gives a tick every clk.
REQ-017 SHALL advance the PWM counter by 1 on each tick, modulo 2^PWM_BITS; wrap is the tick at which the counter goes from max to 0.
REQ-018 SHALL drive channel n high when the counter is less than active_duty[n], then XOR the result with INV. Consequences: duty=0 gives constant low; duty=max gives high for max of 2^PWM_BITS counts.
REQ-019 SHALL double-buffer duty: a DUTY write updates the shadow register only, and the active duty loads from the shadow only at wrap, so no glitched periods occur.
REQ-020 SHALL pulse wrap_o for exactly one clk at each wrap and set STATUS.WRAP at the same time.
REQ-021 SHALL clear STATUS.WRAP on a STATUS read; if a read and a wrap occur in the same cycle, the set wins and dout reports the pre-set value.
REQ-022 SHALL, on an EN 1->0 transition, clear the prescaler and counter and force the pwm_o raw value to 0 (output = INV); shadow registers are retained.
REQ-023 SHALL, on an EN 0->1 transition, copy all shadow duties to the active duties immediately.
REQ-024 SHALL let a PRESC write take effect at the next prescaler restart; if the prescaler count already exceeds the new PRESC, it restarts at 0 on the next clk.

Reset
REQ-025 SHALL clear on rst_n=0, asynchronously: all registers, counters, active and shadow duties, STATUS, and outputs (dout=0x00, pwm_o=0, wrap_o=0).
REQ-026 SHALL resume counting on the first clk edge after rst_n deasserts only once EN has been written to 1.

Configuration
REQ-027 SHALL compile in fading when macro RGB_PWM_FADE_EN is defined: at each wrap, each active duty steps by ±1 toward its shadow instead of loading it directly; the EN 0->1 load stays immediate.
REQ-028 SHALL, without RGB_PWM_FADE_EN, perform a direct shadow load at wrap and contain no fade logic.

Structure
REQ-029 SHALL place the register-address constants (CTRL/PRESC/STATUS/DUTY0) and CTRL bit positions in shared package rgb_pwm_pkg.
REQ-030 SHALL implement one sub-module, pwm_chan, instantiated NCH times: it holds the shadow and active duty and the compare, plus the fade stepper when enabled.

Verification
REQ-031 SHALL cover reset: assert rst_n mid-period with EN=1 and DUTY0=0x80 -> pwm_o=0, dout=0x00 and wrap_o=0 immediately, with no clock required.
REQ-032 SHALL cover duty: PRESC=0, EN=1, DUTY0=0x40, DUTY1=0x00, DUTY2=0xFF -> per 256-clk period, ch0 high 64 clk, ch1 never high, ch2 high 255 clk.
REQ-033 SHALL cover double-buffer: write DUTY0 from 0x10 to 0xF0 mid-period -> the current period stays at 16 high; the next period is 240 high.
REQ-034 SHALL cover STATUS: after a wrap, read STATUS -> 0x01, then read again -> 0x00; a read coincident with a wrap -> the following read returns 0x01.
REQ-035 SHALL cover INV and disable: INV=1 with EN 1->0 -> pwm_o all-ones next clk; counter restarts from 0 when EN is rewritten to 1.
REQ-036 SHALL cover fade (RGB_PWM_FADE_EN): active duty 0x00, shadow 0x04 -> high time per period is 1, 2, 3, 4, then stays at 4.
